keypad_scan_n: RTL and testbench

Parametrised matrix-keypad scanner that replaces the fixed 4×4 scan/debounce logic under the lab top level. It drives one row at a time and samples the column lines at the end of each row dwell. Whole-frame results are debounced through a four-state machine, with single-key lockout, multi-key detection and optional auto-repeat. Accepted key codes are pushed into a DIGITS-deep history register that feeds the multiplexed seven-segment driver. Pad polarity inversion stays in the FPGA wrapper; this block sees active-high rows and cols.

---
 rtl/keypad_scan_n.sv | 231 +++++++++++++++++++++++
 tb/tb_keypad_scan_n.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_n.sv
// Matrix keypad scanner: one-hot row drive, per-frame column sampling,
// frame-level debounce FSM with lockout, multi-key flag, auto-repeat and key history.
module keypad_scan_n #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 12000,
    parameter int DEBOUNCE      = 4,
    parameter int DIGITS        = 2,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_FRAMES = 50,
    localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COLS-1:0]      cols,
    output logic [ROWS-1:0]      rows,
    output logic [KW-1:0]        keyCode,
    output logic                 newNum,
    output logic                 pressed,
    output logic                 idle,
    output logic                 multiKey,
    output logic [DIGITS*KW-1:0] history
);

    localparam int          DW    = $clog2(SCAN_DIV);
    localparam int          RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int          HW    = DIGITS * KW;
    localparam int          MAXC  = (DEBOUNCE > REPEAT_FRAMES) ? DEBOUNCE : REPEAT_FRAMES;
    localparam int          CW    = $clog2(MAXC + 1);
    localparam int unsigned UCOLS = COLS;

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_REL} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_divCnt;
    logic [RW-1:0]   r_rowIdx;
    logic [ROWS-1:0] r_rows;
    logic [COLS-1:0] r_colsS;
    logic [RW-1:0]   r_sampRow;
    logic            r_sampValid;
    logic [1:0]      r_hit;
    logic [KW-1:0]   r_first;
    logic            r_held;
    logic [KW-1:0]   r_cand;
    logic [KW-1:0]   r_keyCode;
    logic [HW-1:0]   r_hist;
    logic [CW-1:0]   r_fcnt;
    logic [CW-1:0]   r_rcnt;
    logic            r_newNum;
    logic            r_pressed;
    logic            r_idle;
    logic            r_multi;

    logic [RW-1:0]   w_rowNext;
    logic [31:0]     w_base;
    logic [1:0]      w_rowCnt;
    logic [KW-1:0]   w_rowFirst;
    logic            w_rowHeld;
    logic [2:0]      w_sum;
    logic [1:0]      w_hitTot;
    logic [KW-1:0]   w_first;
    logic            w_held;
    logic            w_frameEnd;
    logic            w_single;
    logic            w_accept;
    logic            w_repeat;
    logic [KW-1:0]   w_shiftCode;

    assign w_rowNext = (r_rowIdx == RW'(ROWS - 1)) ? '0 : r_rowIdx + 1'b1;
    assign w_base    = 32'(r_sampRow) * UCOLS;

    // Decode the row sampled on the previous edge into count / lowest code / cand hit.
    always_comb begin
        w_rowCnt   = '0;
        w_rowFirst = '0;
        w_rowHeld  = 1'b0;
        for (int unsigned c = 0; c < UCOLS; c++) begin
            if (r_colsS[c]) begin
                if (w_rowCnt == 2'd0) w_rowFirst = KW'(w_base + c);
                if (w_rowCnt != 2'd2) w_rowCnt = w_rowCnt + 2'd1;
                if (KW'(w_base + c) == r_cand) w_rowHeld = 1'b1;
            end
        end
    end

    assign w_sum      = {1'b0, r_hit} + {1'b0, w_rowCnt};
    assign w_hitTot   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_first    = (r_hit == 2'd0) ? w_rowFirst : r_first;
    assign w_held     = r_held | w_rowHeld;
    assign w_frameEnd = r_sampValid && (r_sampRow == RW'(ROWS - 1));
    assign w_single   = (w_hitTot == 2'd1);

    assign w_accept = w_frameEnd && w_single &&
                      ((r_state == S_IDLE && DEBOUNCE == 1) ||
                       (r_state == S_DEB && w_first == r_cand &&
                        (r_fcnt + CW'(1)) == CW'(DEBOUNCE)));
    assign w_repeat = w_frameEnd && (REPEAT_EN != 0) && (r_state == S_HELD) && w_held &&
                      (r_rcnt + CW'(1)) == CW'(REPEAT_FRAMES);
    assign w_shiftCode = w_accept ? w_first : r_cand;

    // Scan engine: row dwell counter, column sample register, frame accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divCnt    <= '0;
            r_rowIdx    <= '0;
            r_rows      <= ROWS'(1);
            r_colsS     <= '0;
            r_sampRow   <= '0;
            r_sampValid <= 1'b0;
            r_hit       <= '0;
            r_first     <= '0;
            r_held      <= 1'b0;
        end else begin
            r_sampValid <= 1'b0;
            if (r_divCnt == DW'(SCAN_DIV - 1)) begin
                r_divCnt    <= '0;
                r_colsS     <= cols;
                r_sampRow   <= r_rowIdx;
                r_sampValid <= 1'b1;
                r_rowIdx    <= w_rowNext;
                r_rows      <= ROWS'(1) << w_rowNext;
            end else begin
                r_divCnt <= r_divCnt + 1'b1;
            end
            if (r_sampValid) begin
                if (w_frameEnd) begin
                    r_hit   <= '0;
                    r_first <= '0;
                    r_held  <= 1'b0;
                end else begin
                    r_hit   <= w_hitTot;
                    r_first <= w_first;
                    r_held  <= w_held;
                end
            end
        end
    end

    // Debounce / hold / release FSM, evaluated once per frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cand    <= '0;
            r_keyCode <= '0;
            r_hist    <= '0;
            r_fcnt    <= '0;
            r_rcnt    <= '0;
            r_newNum  <= 1'b0;
            r_pressed <= 1'b0;
            r_idle    <= 1'b1;
            r_multi   <= 1'b0;
        end else begin
            r_newNum <= w_accept | w_repeat;
            if (w_accept | w_repeat) begin
                r_keyCode <= w_shiftCode;
                r_hist    <= (r_hist << KW) | HW'(w_shiftCode);
            end
            if (w_frameEnd) begin
                r_multi <= (w_hitTot == 2'd2);
                if (w_accept) begin
                    r_cand    <= w_first;
                    r_state   <= S_HELD;
                    r_fcnt    <= '0;
                    r_rcnt    <= '0;
                    r_pressed <= 1'b1;
                    r_idle    <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_single) begin
                                r_cand  <= w_first;
                                r_fcnt  <= CW'(1);
                                r_state <= S_DEB;
                                r_idle  <= 1'b0;
                            end
                        end
                        S_DEB: begin
                            if (w_single && w_first == r_cand) begin
                                r_fcnt <= r_fcnt + CW'(1);
                            end else begin
                                r_state <= S_IDLE;
                                r_fcnt  <= '0;
                                r_idle  <= 1'b1;
                            end
                        end
                        S_HELD: begin
                            if (w_held) begin
                                if (REPEAT_EN != 0) r_rcnt <= w_repeat ? '0 : r_rcnt + CW'(1);
                            end else if (DEBOUNCE == 1) begin
                                r_state   <= S_IDLE;
                                r_rcnt    <= '0;
                                r_pressed <= 1'b0;
                                r_idle    <= 1'b1;
                            end else begin
                                r_state <= S_REL;
                                r_fcnt  <= CW'(1);
                                r_rcnt  <= '0;
                            end
                        end
                        S_REL: begin
                            if (!w_held) begin
                                if ((r_fcnt + CW'(1)) == CW'(DEBOUNCE)) begin
                                    r_state   <= S_IDLE;
                                    r_fcnt    <= '0;
                                    r_pressed <= 1'b0;
                                    r_idle    <= 1'b1;
                                end else begin
                                    r_fcnt <= r_fcnt + CW'(1);
                                end
                            end else begin
                                r_state <= S_HELD;
                                r_fcnt  <= '0;
                                r_rcnt  <= '0;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign rows     = r_rows;
    assign keyCode  = r_keyCode;
    assign newNum   = r_newNum;
    assign pressed  = r_pressed;
    assign idle     = r_idle;
    assign multiKey = r_multi;
    assign history  = r_hist;

endmodule

// File: tb/tb_keypad_scan_n.sv
// Bench for keypad_scan_n: a simulated 4x4 key matrix drives two scanners (repeat off/on),
// checked every cycle against a frame-level behavioural model plus directed literal checks.
module tb_keypad_scan_n;

    localparam int DEB = 3;

    typedef enum {PH_WAIT, PH_CONFIRM, PH_HOLD, PH_LETGO} ph_t;

    logic        clk;
    logic        reset;
    logic [15:0] keys;

    logic [3:0] rows0, rows1, cols0, cols1, key0, key1;
    logic       nn0, nn1, pr0, pr1, id0, id1, mk0, mk1;
    logic [7:0] hist0, hist1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 0;
    int pulses[2];

    logic [15:0] fkeys;
    logic [3:0]  exp_rows;
    bit          exp_nn[2];
    ph_t         m_phase[2];
    int          m_cand[2], m_cnt[2], m_rcnt[2], m_key[2];
    logic [7:0]  m_hist[2];
    bit          m_multi[2];
    int          rep_en[2] = '{0, 1};
    int          rep_fr[2] = '{50, 5};

    function automatic logic [3:0] cols_of(input logic [3:0] r, input logic [15:0] k);
        logic [3:0] res = '0;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (r[rr] && k[rr*4+cc]) res[cc] = 1'b1;
        return res;
    endfunction

    assign cols0 = cols_of(rows0, keys);
    assign cols1 = cols_of(rows1, keys);

    keypad_scan_n #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEB), .DIGITS(2),
                    .REPEAT_EN(0), .REPEAT_FRAMES(50)) u_dut0 (
        .clk(clk), .reset(reset), .cols(cols0), .rows(rows0), .keyCode(key0),
        .newNum(nn0), .pressed(pr0), .idle(id0), .multiKey(mk0), .history(hist0));

    keypad_scan_n #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEB), .DIGITS(2),
                    .REPEAT_EN(1), .REPEAT_FRAMES(5)) u_dut1 (
        .clk(clk), .reset(reset), .cols(cols1), .rows(rows1), .keyCode(key1),
        .newNum(nn1), .pressed(pr1), .idle(id1), .multiKey(mk1), .history(hist1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = PH_WAIT;
            m_cand[d]  = 0;
            m_cnt[d]   = 0;
            m_rcnt[d]  = 0;
            m_key[d]   = 0;
            m_hist[d]  = '0;
            m_multi[d] = 0;
            exp_nn[d]  = 0;
        end
        fkeys = '0;
    endtask

    task automatic emit(input int d);
        m_key[d]  = m_cand[d];
        m_hist[d] = {m_hist[d][3:0], 4'(m_cand[d])};
        exp_nn[d] = 1;
    endtask

    // One whole frame seen with key set k.
    task automatic model_step(input int d, input logic [15:0] k);
        int n;
        int first;
        bit held;
        n = $countones(k);
        first = 0;
        for (int i = 15; i >= 0; i--) if (k[i]) first = i;
        held = k[m_cand[d]];
        m_multi[d] = (n >= 2);
        case (m_phase[d])
            PH_WAIT: if (n == 1) begin
                m_cand[d] = first;
                m_cnt[d]  = 1;
                if (m_cnt[d] == DEB) begin emit(d); m_phase[d] = PH_HOLD; m_rcnt[d] = 0; end
                else m_phase[d] = PH_CONFIRM;
            end
            PH_CONFIRM: if (n == 1 && first == m_cand[d]) begin
                m_cnt[d]++;
                if (m_cnt[d] == DEB) begin emit(d); m_phase[d] = PH_HOLD; m_rcnt[d] = 0; end
            end else m_phase[d] = PH_WAIT;
            PH_HOLD: if (held) begin
                if (rep_en[d] != 0) begin
                    m_rcnt[d]++;
                    if (m_rcnt[d] == rep_fr[d]) begin emit(d); m_rcnt[d] = 0; end
                end
            end else begin
                m_cnt[d]   = 1;
                m_phase[d] = (DEB == 1) ? PH_WAIT : PH_LETGO;
            end
            PH_LETGO: if (!held) begin
                m_cnt[d]++;
                if (m_cnt[d] == DEB) m_phase[d] = PH_WAIT;
            end else begin
                m_phase[d] = PH_HOLD;
                m_rcnt[d]  = 0;
            end
            default: m_phase[d] = PH_WAIT;
        endcase
    endtask

    // Frame f's result appears in cycle 16f+17 (sample at 16f+15, evaluate one edge later).
    task automatic begin_cycle();
        exp_rows = 4'(1 << ((cyc / 4) % 4));
        for (int d = 0; d < 2; d++) exp_nn[d] = 0;
        if (cyc % 16 == 15) fkeys = keys;
        if (cyc % 16 == 1 && cyc >= 17)
            for (int d = 0; d < 2; d++) model_step(d, fkeys);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        begin_cycle();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_keys(input logic [15:0] m);
        while (cyc % 16 != 0) step();
        keys = m;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc = 0;
            model_reset();
            begin_cycle();
            chk_en = 1;
        end
        reset = 1'b0;
    endtask

    task automatic check_dut(input int d, input logic [3:0] r, input logic [3:0] k,
                             input logic nn, input logic pr, input logic id,
                             input logic mk, input logic [7:0] h);
        chk($sformatf("dut%0d.rows", d), 32'(r), 32'(exp_rows));
        chk($sformatf("dut%0d.keyCode", d), 32'(k), 32'(m_key[d]));
        chk($sformatf("dut%0d.newNum", d), 32'(nn), 32'(exp_nn[d]));
        chk($sformatf("dut%0d.pressed", d), 32'(pr), 32'(m_phase[d] == PH_HOLD || m_phase[d] == PH_LETGO));
        chk($sformatf("dut%0d.idle", d), 32'(id), 32'(m_phase[d] == PH_WAIT));
        chk($sformatf("dut%0d.multiKey", d), 32'(mk), 32'(m_multi[d]));
        chk($sformatf("dut%0d.history", d), 32'(h), 32'(m_hist[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, rows0, key0, nn0, pr0, id0, mk0, hist0);
            check_dut(1, rows1, key1, nn1, pr1, id1, mk1, hist1);
            if (nn0 === 1'b1) pulses[0]++;
            if (nn1 === 1'b1) pulses[1]++;
        end
    end

    initial begin
        int p0, p1, len, pat, frames, ka, kb;
        logic [15:0] m;
        reset = 1'b1;
        keys  = '0;
        pulses[0] = 0;
        pulses[1] = 0;
        model_reset();
        do_reset(2);

        chk("rst_rows", 32'(rows0), 32'h1);
        chk("rst_idle", 32'(id0), 32'h1);
        chk("rst_pressed", 32'(pr0), 32'h0);
        chk("rst_history", 32'(hist0), 32'h0);

        // Clean press of key 9 (row 2, col 1) from frame start.
        keys = 16'h0200;
        run(4);
        chk("scan_rows_row1", 32'(rows0), 32'h2);
        run(44);
        chk("press_before", 32'(nn0), 32'h0);
        run(1);
        chk("press_newNum", 32'(nn0), 32'h1);
        chk("press_key", 32'(key0), 32'd9);
        chk("press_hist0", 32'(hist0[3:0]), 32'd9);
        chk("press_pressed", 32'(pr0), 32'h1);
        chk("press_idle", 32'(id0), 32'h0);
        chk("model_key_pin", 32'(m_key[0]), 32'd9);
        set_keys(16'h0000);
        run(64);
        chk("release_pulses", 32'(pulses[0]), 32'd1);
        chk("release_pressed", 32'(pr0), 32'h0);
        chk("release_idle", 32'(id0), 32'h1);

        // Bounce: two frames then absent.
        p0 = pulses[0];
        set_keys(16'h0200);
        run(32);
        set_keys(16'h0000);
        run(32);
        chk("bounce_pulses", 32'(pulses[0] - p0), 32'd0);
        chk("bounce_idle", 32'(id0), 32'h1);

        // Lockout: hold 9, add 5, then drop 9.
        p0 = pulses[0];
        set_keys(16'h0200);
        run(48);
        set_keys(16'h0220);
        run(32);
        chk("lock_multiKey", 32'(mk0), 32'h1);
        chk("lock_pulses_mid", 32'(pulses[0] - p0), 32'd1);
        set_keys(16'h0020);
        run(96);
        set_keys(16'h0000);
        run(64);
        chk("lock_pulses", 32'(pulses[0] - p0), 32'd2);
        chk("lock_key", 32'(key0), 32'd5);
        chk("lock_history", 32'(hist0), 32'h95);
        chk("model_hist_pin", 32'(m_hist[0]), 32'h95);

        // Auto-repeat: key 3 held 20 frames.
        p0 = pulses[0];
        p1 = pulses[1];
        set_keys(16'h0008);
        run(320);
        set_keys(16'h0000);
        run(64);
        chk("repeat_pulses_on", 32'(pulses[1] - p1), 32'd4);
        chk("repeat_pulses_off", 32'(pulses[0] - p0), 32'd1);
        chk("repeat_history", 32'(hist1), 32'h33);

        // Reset during the third debounce frame of key 6.
        p0 = pulses[0];
        set_keys(16'h0040);
        run(37);
        do_reset(2);
        chk("rstmid_pulses", 32'(pulses[0] - p0), 32'd0);
        chk("rstmid_idle", 32'(id0), 32'h1);
        chk("rstmid_history", 32'(hist0), 32'h0);
        chk("rstmid_rows", 32'(rows0), 32'h1);
        run(48);
        chk("rstmid_before", 32'(nn0), 32'h0);
        run(1);
        chk("rstmid_newNum", 32'(nn0), 32'h1);
        chk("rstmid_key", 32'(key0), 32'd6);
        set_keys(16'h0000);
        run(64);

        // Random key patterns, changed only at frame boundaries.
        frames = 0;
        while (frames < 90) begin
            pat = $urandom_range(0, 9);
            len = $urandom_range(1, 6);
            ka  = $urandom_range(0, 15);
            kb  = $urandom_range(0, 15);
            m   = '0;
            if (pat >= 4) m[ka] = 1'b1;
            if (pat >= 8) m[kb] = 1'b1;
            set_keys(m);
            run(16 * len);
            frames += len;
        end
        set_keys(16'h0000);
        run(80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
